// File: rtl/i2c_rx_framer_if.sv
// i2c_rx_framer_if: bus-side inputs and framed-byte outputs of the I2C receive framer
interface i2c_rx_framer_if;
    logic       scl_in;
    logic       sda_in;
    logic       rising_edge_found;
    logic       falling_edge_found;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic       start_found;
    logic       stop_found;
    logic       framing_error;
    logic       sda_ack_low;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, rising_edge_found, falling_edge_found,
        output rx_data, byte_valid, start_found, stop_found, framing_error, sda_ack_low, busy
    );

    modport master (
        output scl_in, sda_in, rising_edge_found, falling_edge_found,
        input  rx_data, byte_valid, start_found, stop_found, framing_error, sda_ack_low, busy
    );
endinterface

// File: rtl/i2c_rx_framer.sv
// i2c_rx_framer: detects START/STOP, deserialises MSB-first bytes and drives the 9th-clock ACK
module i2c_rx_framer #(
    parameter bit ACK_ENABLE = 1'b1
) (
    input logic            clk,
    input logic            n_rst,
    i2c_rx_framer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, ACK_WAIT, ACK_DRIVE} state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       sda_prev;
    logic       start;
    logic       stop;
    logic       mid_byte;

    always_comb begin
        start    = bus.scl_in & sda_prev & ~bus.sda_in;
        stop     = bus.scl_in & ~sda_prev & bus.sda_in;
        mid_byte = (state == SHIFT && bit_cnt != 4'd0) || state == ACK_WAIT;
    end

    // START/STOP outrank any SCL edge pulse arriving in the same cycle
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state             <= IDLE;
            bit_cnt           <= 4'd0;
            shift_reg         <= 8'd0;
            sda_prev          <= 1'b1;
            bus.rx_data       <= 8'd0;
            bus.byte_valid    <= 1'b0;
            bus.start_found   <= 1'b0;
            bus.stop_found    <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.sda_ack_low   <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            sda_prev          <= bus.sda_in;
            bus.byte_valid    <= 1'b0;
            bus.start_found   <= 1'b0;
            bus.stop_found    <= 1'b0;
            bus.framing_error <= 1'b0;
            if (start) begin
                bus.start_found   <= 1'b1;
                bus.framing_error <= mid_byte;
                bus.sda_ack_low   <= 1'b0;
                bus.busy          <= 1'b1;
                bit_cnt           <= 4'd0;
                state             <= SHIFT;
            end else if (stop && state != IDLE) begin
                bus.stop_found    <= 1'b1;
                bus.framing_error <= mid_byte;
                bus.sda_ack_low   <= 1'b0;
                bus.busy          <= 1'b0;
                state             <= IDLE;
            end else begin
                case (state)
                    SHIFT: if (bus.rising_edge_found) begin
                        shift_reg <= {shift_reg[6:0], bus.sda_in};
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bus.rx_data    <= {shift_reg[6:0], bus.sda_in};
                            bus.byte_valid <= 1'b1;
                            state          <= ACK_WAIT;
                        end
                    end
                    ACK_WAIT: if (bus.falling_edge_found) begin
                        bus.sda_ack_low <= ACK_ENABLE;
                        state           <= ACK_DRIVE;
                    end
                    ACK_DRIVE: if (bus.falling_edge_found) begin
                        bus.sda_ack_low <= 1'b0;
                        bit_cnt         <= 4'd0;
                        state           <= SHIFT;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/i2c_rx_framer.md
I2C_RX_FRAMER -- requirements
Module: i2c_rx_framer

Interface
REQ-001 Parameter ACK_ENABLE, default 1: 1 = drive ACK in the 9th SCL period; 0 = never drive ACK.
REQ-002 clk  in  1  system clock; all logic SHALL be rising-edge triggered on clk.
REQ-003 n_rst  in  1  reset; synchronous and active-high (asserted = 1, sampled on the clk rising edge).
REQ-004 scl_in  in  1  synchronized SCL level.
REQ-005 sda_in  in  1  synchronized SDA level.
REQ-006 rising_edge_found  in  1  one-cycle pulse from the SCL edge detector; SCL rose.
REQ-007 falling_edge_found  in  1  one-cycle pulse from the SCL edge detector; SCL fell.
REQ-008 rx_data  out  8  last completed byte, MSB first on the wire.
REQ-009 byte_valid  out  1  one-cycle pulse when rx_data updates.
REQ-010 start_found  out  1  one-cycle pulse on START or repeated START.
REQ-011 stop_found  out  1  one-cycle pulse on STOP.
REQ-012 framing_error  out  1  one-cycle pulse on START or STOP arriving mid-byte.
REQ-013 sda_ack_low  out  1  1 = pull SDA low (ACK).
REQ-014 busy  out  1  1 whenever state != IDLE.

Function
REQ-015 The block SHALL register sda_in into sda_prev every cycle.
REQ-016 START SHALL be the condition scl_in=1, sda_prev=1, sda_in=0 in the same cycle.
REQ-017 STOP SHALL be the condition scl_in=1, sda_prev=0, sda_in=1 in the same cycle.
REQ-018 States SHALL be IDLE, SHIFT, ACK_WAIT and ACK_DRIVE.
REQ-019 IDLE: on START, go to SHIFT; bit_cnt=0; start_found pulses. All other inputs are ignored.
REQ-020 SHIFT: on rising_edge_found, shift sda_in into the LSB of a shift register and increment the 4-bit bit_cnt.
REQ-021 SHIFT: on the 8th sample, the next cycle SHALL load rx_data, pulse byte_valid for one cycle and enter ACK_WAIT.
REQ-022 ACK_WAIT: on falling_edge_found, go to ACK_DRIVE; sda_ack_low=ACK_ENABLE from the next cycle.
REQ-023 ACK_DRIVE: rising_edge_found SHALL NOT sample data.
REQ-024 ACK_DRIVE: on falling_edge_found (end of the 9th clock), clear sda_ack_low the next cycle, set bit_cnt=0 and return to SHIFT.
REQ-025 START in SHIFT, ACK_WAIT or ACK_DRIVE SHALL pulse start_found, clear sda_ack_low, set bit_cnt=0 and enter SHIFT.
REQ-026 For the START in REQ-025, framing_error SHALL also pulse if the state is SHIFT with bit_cnt != 0 or the state is ACK_WAIT.
REQ-027 STOP in any non-IDLE state SHALL pulse stop_found, clear sda_ack_low and enter IDLE.
REQ-028 For the STOP in REQ-027, framing_error SHALL also pulse under the same conditions as REQ-026.
REQ-029 When START or STOP coincides with an SCL edge pulse in the same cycle, START/STOP SHALL take priority and the edge SHALL be ignored.
REQ-030 rx_data SHALL hold its value until the next byte completes; partial bytes SHALL never reach rx_data.
REQ-031 All pulse outputs SHALL be registered and high for exactly one clk cycle.

Reset
REQ-032 n_rst=1 SHALL force the following values at the next clk edge, regardless of state or bus activity: state=IDLE, bit_cnt=0, shift register=0, rx_data=0x00, sda_prev=1.
REQ-033 n_rst=1 SHALL also force all pulse outputs=0, sda_ack_low=0 and busy=0.
REQ-034 After reset deasserts, the block SHALL stay in IDLE until a START is detected; a reset mid-byte SHALL discard the partial byte.

Verification
REQ-035 Scenario 1: START, 8 bits 0xA5, 9th clock, STOP -> start_found once; rx_data=0xA5; byte_valid for one cycle after the 8th rising edge; sda_ack_low=1 between the 8th and 9th falling edges; stop_found once; busy=0 at the end.
REQ-036 Scenario 2: START, 0x3C with ACK, then 0xFF with ACK, then STOP -> byte_valid twice; rx_data=0x3C then 0xFF; no framing_error.
REQ-037 Scenario 3: START, 3 bits 1,0,1, then STOP -> framing_error and stop_found pulse in the same cycle; rx_data unchanged (0x00); state IDLE.
REQ-038 Scenario 4: START, 5 bits, then repeated START, then 0x81 -> framing_error and start_found on the repeated START; the next byte_valid gives rx_data=0x81.
REQ-039 Scenario 5: n_rst=1 for one cycle after 4 bits of a byte -> all outputs 0; later SCL edges ignored until a new START; the following byte 0x5A is received correctly.
REQ-040 Scenario 6: ACK_ENABLE=0, START, 0xA5 -> byte_valid with rx_data=0xA5; sda_ack_low stays 0 throughout the 9th clock.
